// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler plus 24-hour BCD time-of-day counter with
// front-panel minute/hour setting and an HH:MM:00 alarm strobe.
module time_keeper #(
  parameter int CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_min_inc,
  input  logic       set_hr_inc,
  input  logic       alarm_en,
  input  logic [1:0] alarm_hr_tens,
  input  logic [3:0] alarm_hr_ones,
  input  logic [2:0] alarm_min_tens,
  input  logic [3:0] alarm_min_ones,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       sec_tick,
  output logic       alarm_hit
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [2:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [2:0]    min_tens_q, min_tens_d;
  logic [3:0]    hr_ones_q, hr_ones_d;
  logic [1:0]    hr_tens_q, hr_tens_d;
  logic          sec_tick_q, sec_tick_d;
  logic          alarm_hit_q, alarm_hit_d;

  logic set_any;
  logic tick;
  logic sec_wrap;
  logic min_wrap;
  logic alarm_match;

  assign set_any = set_min_inc | set_hr_inc;
  // A set pulse owns the cycle: it clears the prescaler and swallows any tick.
  assign tick    = run & ~set_any & (presc_q == PRESC_TC);

  // Prescaler: free-runs while run=1, cleared by any set pulse, holds otherwise.
  always_comb begin
    presc_d = presc_q;
    if (set_any)
      presc_d = '0;
    else if (run)
      presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + 1'b1;
  end

  assign sec_wrap = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
  assign min_wrap = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);

  // Digit next-state: set increments take priority over the second tick.
  always_comb begin
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hr_ones_d   = hr_ones_q;
    hr_tens_d   = hr_tens_q;
    sec_tick_d  = 1'b0;

    if (set_any) begin
      if (set_min_inc) begin
        // Minute wraps 59->00 on its own; no carry into the hour.
        sec_ones_d = 4'd0;
        sec_tens_d = 3'd0;
        if (min_ones_q == 4'd9) begin
          min_ones_d = 4'd0;
          min_tens_d = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
        end else begin
          min_ones_d = min_ones_q + 4'd1;
        end
      end
      if (set_hr_inc) begin
        if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
          hr_tens_d = 2'd0;
          hr_ones_d = 4'd0;
        end else if (hr_ones_q == 4'd9) begin
          hr_ones_d = 4'd0;
          hr_tens_d = hr_tens_q + 2'd1;
        end else begin
          hr_ones_d = hr_ones_q + 4'd1;
        end
      end
    end else if (tick) begin
      sec_tick_d = 1'b1;
      // Seconds ripple into minutes, minutes into hours, all in one edge.
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (!sec_wrap) begin
          sec_tens_d = sec_tens_q + 3'd1;
        end else begin
          sec_tens_d = 3'd0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            if (!min_wrap) begin
              min_tens_d = min_tens_q + 3'd1;
            end else begin
              min_tens_d = 3'd0;
              if (hr_tens_q == 2'd2 && hr_ones_q == 4'd3) begin
                hr_tens_d = 2'd0;
                hr_ones_d = 4'd0;
              end else if (hr_ones_q == 4'd9) begin
                hr_ones_d = 4'd0;
                hr_tens_d = hr_tens_q + 2'd1;
              end else begin
                hr_ones_d = hr_ones_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Alarm compares the post-tick time; legal counters never hold out-of-range
  // BCD, so an out-of-range alarm setting simply never matches.
  assign alarm_match = (sec_ones_d == 4'd0) && (sec_tens_d == 3'd0) &&
                       (min_ones_d == alarm_min_ones) &&
                       (min_tens_d == alarm_min_tens) &&
                       (hr_ones_d  == alarm_hr_ones) &&
                       (hr_tens_d  == alarm_hr_tens);

  // Alarm strobe only on a genuine tick; set cycles have tick forced low.
  always_comb begin
    alarm_hit_d = tick & alarm_en & alarm_match;
  end

  // State registers with synchronous reset to 00:00:00.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 3'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 3'd0;
      hr_ones_q   <= 4'd0;
      hr_tens_q   <= 2'd0;
      sec_tick_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hr_ones_q   <= hr_ones_d;
      hr_tens_q   <= hr_tens_d;
      sec_tick_q  <= sec_tick_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign hr_ones   = hr_ones_q;
  assign hr_tens   = hr_tens_q;
  assign sec_tick  = sec_tick_q;
  assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed sequence with a per-cycle scoreboard fed by a
// decimal reference model, plus directed timing/boundary checks.
module tb_time_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, smin, shr, aen;
  logic [1:0] a_ht;
  logic [3:0] a_ho;
  logic [2:0] a_mt;
  logic [3:0] a_mo;
  logic [3:0] sec_ones, min_ones, hr_ones;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hr_tens;
  logic       sec_tick, alarm_hit;

  time_keeper #(.CLK_HZ(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .set_min_inc(smin), .set_hr_inc(shr), .alarm_en(aen),
    .alarm_hr_tens(a_ht), .alarm_hr_ones(a_ho),
    .alarm_min_tens(a_mt), .alarm_min_ones(a_mo),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .sec_tick(sec_tick), .alarm_hit(alarm_hit)
  );

  wire [21:0] obs = {hr_tens, hr_ones, min_tens, min_ones,
                     sec_tens, sec_ones, sec_tick, alarm_hit};

  int n_asserts = 0;
  int n_fails   = 0;
  int m_h = 0, m_m = 0, m_s = 0, m_p = 0;
  logic [21:0] sb[$];

  function automatic logic [21:0] pack(int h, int m, int s, bit t, bit a);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), t, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock: model the cycle, push expectation, then pop and compare.
  task automatic cyc();
    bit t, a;
    logic [21:0] exp;
    t = 0; a = 0;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_p = 0;
    end else if (smin || shr) begin
      if (smin) begin m_m = (m_m + 1) % 60; m_s = 0; end
      if (shr)  m_h = (m_h + 1) % 24;
      m_p = 0;
    end else if (run) begin
      if (m_p == 3) begin
        m_p = 0;
        m_s++;
        if (m_s == 60) begin
          m_s = 0; m_m++;
          if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
        end
        t = 1;
        a = aen && (m_s == 0) &&
            ((m_m / 10) == int'(a_mt)) && ((m_m % 10) == int'(a_mo)) &&
            ((m_h / 10) == int'(a_ht)) && ((m_h % 10) == int'(a_ho));
      end else begin
        m_p++;
      end
    end
    sb.push_back(pack(m_h, m_m, m_s, t, a));
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check("cycle", 32'(obs), 32'(exp));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1; run = 0; smin = 0; shr = 0;
    cyc();
    rst = 0;
  endtask

  task automatic pulse(input bit mi, input bit hi);
    smin = mi; shr = hi;
    cyc();
    smin = 0; shr = 0;
  endtask

  // Cycles until sec_tick is seen; -1 if the budget expires.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (sec_tick === 1'b1) begin n = i; break; end
    end
  endtask

  // Count pulses of sec_tick / alarm_hit over n cycles.
  task automatic count_pulses(input int n, output int ticks, output int hits);
    ticks = 0; hits = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (sec_tick === 1'b1) ticks++;
      if (alarm_hit === 1'b1) hits++;
    end
  endtask

  initial begin
    int n, tk, hk;
    rst = 1; run = 0; smin = 0; shr = 0; aen = 0;
    a_ht = 0; a_ho = 0; a_mt = 0; a_mo = 0;

    // Reset and basic tick spacing.
    do_reset();
    check("reset_state", 32'(obs), 32'(pack(0, 0, 0, 0, 0)));
    run = 1;
    wait_tick(n); check("tick1_lat", n, 4);
    check("tick1_val", 32'(obs), 32'(pack(0, 0, 1, 1, 0)));
    wait_tick(n); check("tick2_lat", n, 4);
    wait_tick(n); check("tick3_lat", n, 4);
    check("tick3_val", 32'(obs), 32'(pack(0, 0, 3, 1, 0)));

    // Full-day rollover.
    do_reset();
    for (int i = 0; i < 23; i++) pulse(0, 1);
    for (int i = 0; i < 59; i++) pulse(1, 0);
    check("set_2359", 32'(obs), 32'(pack(23, 59, 0, 0, 0)));
    run = 1;
    run_n(59 * 4);
    check("at_235959", 32'(obs), 32'(pack(23, 59, 59, 1, 0)));
    count_pulses(4, tk, hk);
    check("roll_ticks", tk, 1);
    check("roll_hits", hk, 0);
    check("roll_000000", 32'(obs), 32'(pack(0, 0, 0, 1, 0)));

    // Freeze with run=0 at prescaler=2.
    do_reset();
    run = 1; run_n(2);
    run = 0;
    count_pulses(10, tk, hk);
    check("freeze_ticks", tk, 0);
    check("freeze_val", 32'(obs), 32'(pack(0, 0, 0, 0, 0)));
    run = 1;
    wait_tick(n); check("resume_lat", n, 2);

    // set_min_inc at 00:59:37 while running, mid-prescale.
    do_reset();
    for (int i = 0; i < 59; i++) pulse(1, 0);
    run = 1;
    run_n(37 * 4 + 1);
    check("at_005937", 32'(obs[21:2]), 32'(pack(0, 59, 37, 0, 0) >> 2));
    pulse(1, 0);
    check("setmin_wrap", 32'(obs), 32'(pack(0, 0, 0, 0, 0)));
    wait_tick(n); check("set_tick_lat", n, 4);

    // Both set pulses together at 05:10:20.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(0, 1);
    for (int i = 0; i < 10; i++) pulse(1, 0);
    run = 1; run_n(20 * 4); run = 0;
    check("at_051020", 32'(obs), 32'(pack(5, 10, 20, 1, 0)));
    pulse(1, 1);
    check("set_both", 32'(obs), 32'(pack(6, 11, 0, 0, 0)));

    // Alarm at 00:01 enabled, then disabled, then reached via set.
    a_ht = 0; a_ho = 0; a_mt = 0; a_mo = 1;
    aen = 1;
    do_reset(); run = 1;
    count_pulses(60 * 4 + 4, tk, hk);
    check("alarm_hits_en", hk, 1);
    aen = 0;
    do_reset(); run = 1;
    count_pulses(60 * 4 + 4, tk, hk);
    check("alarm_hits_dis", hk, 0);
    aen = 1;
    do_reset();
    pulse(1, 0);
    check("alarm_via_set", 32'(obs), 32'(pack(0, 1, 0, 0, 0)));
    // Out-of-range alarm minute ones never matches.
    a_mo = 4'd11;
    do_reset(); run = 1;
    count_pulses(60 * 4 + 4, tk, hk);
    check("alarm_oor", hk, 0);
    aen = 0;

    // Reset mid-count at 12:34:56, prescaler=3.
    do_reset();
    for (int i = 0; i < 12; i++) pulse(0, 1);
    for (int i = 0; i < 34; i++) pulse(1, 0);
    run = 1;
    run_n(56 * 4 + 3);
    check("at_123456", 32'(obs[21:2]), 32'(pack(12, 34, 56, 0, 0) >> 2));
    rst = 1; cyc(); rst = 0;
    check("rst_mid", 32'(obs), 32'(pack(0, 0, 0, 0, 0)));
    wait_tick(n); check("rst_tick_lat", n, 4);
    check("rst_tick_val", 32'(obs), 32'(pack(0, 0, 1, 1, 0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
